fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter EXTRA_FLUSH, default 1, number of flush cycles after the redirect cycle; legal range 0..3.
REQ-002 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-003 Timing: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, sampled only on rising clk.
REQ-006 stall  in  1  hold PC and fetched instruction (hazard unit).
REQ-007 branch_taken  in  1  redirect request from execute stage.
REQ-008 branch_target  in  8  byte address of redirect target.
REQ-009 imem_addr  out  8  instruction memory read address (combinational read memory).
REQ-010 imem_data  in  32  instruction word at imem_addr, same cycle.
REQ-011 PC  out  8  byte address of the instruction presented to IF/ID.
REQ-012 instruction  out  32  fetched instruction to IF/ID.
REQ-013 unvalid_PC  out  1  flush to IF/ID; when high the IF/ID stage loads zeros.
REQ-014 misalign_err  out  1  sticky; set on a redirect to a target with bits [1:0] != 0.

Function
REQ-015 The PC register holds a word-aligned byte address; bits [1:0] are always 0.
REQ-016 imem_addr, PC and instruction are combinational from the PC register: imem_addr = PC, instruction = imem_data.
REQ-017 Next-PC priority, per rising clk with rst low: branch_taken > stall > sequential.
  - branch_taken=1: PC <= {branch_target[7:2],2'b00}, regardless of stall.
  - stall=1, no branch: PC holds.
  - otherwise: PC <= PC+4, modulo 256 (8'hFC wraps to 8'h00, no error).
REQ-018 The FSM has two states, RUN and FLUSH, with a 2-bit flush counter fcnt.
REQ-019 In RUN, branch_taken=1 with EXTRA_FLUSH>0: go to FLUSH, fcnt <= EXTRA_FLUSH.
REQ-020 In RUN, branch_taken=1 with EXTRA_FLUSH=0: stay in RUN.
REQ-021 In FLUSH, each clk decrements fcnt; at fcnt=1, return to RUN.
REQ-022 In FLUSH, a new branch_taken reloads fcnt to EXTRA_FLUSH and redirects PC; the latest branch wins.
REQ-023 Stall freezes neither the flush counter nor the FSM.
REQ-024 unvalid_PC = branch_taken OR (state==FLUSH), combinational.
  - The wrong-path instruction in the redirect cycle is killed.
  - EXTRA_FLUSH further cycles are killed.
REQ-025 While branch_taken=0, state==RUN and stall=0, one new instruction is delivered per cycle with zero added latency.
REQ-026 misalign_err sets on the clk where branch_taken=1 and branch_target[1:0]!=0; it clears only on reset.

Reset
REQ-027 When rst=1 on a rising clk:
  - PC <= RESET_PC with bits [1:0] forced to 0;
  - state <= RUN, fcnt <= 0, misalign_err <= 0.
  Reset overrides branch_taken and stall.
REQ-028 Reset mid-flush abandons the flush; unvalid_PC follows only branch_taken in the cycle after reset.
REQ-029 There is no initial block reliance; all state is defined by rst.

Structure
REQ-030 The shared pipeline package holds:
  - PC_W=8, INSTR_W=32, PC_STEP=4;
  - the RUN/FLUSH state encoding;
  - the NOP constant 32'h0.
REQ-031 A single sub-module, pc_next_mux, implements the combinational next-PC select of REQ-017; the FSM, counter and registers live in fetch_unit.
REQ-032 There are no other sub-modules and no memory inside the block; instruction memory is external.

Verification
REQ-033 Reset, then 4 free clks, imem returns addr-tagged words -> PC sequence 00,04,08,0C,10; unvalid_PC=0 throughout.
REQ-034 PC=8'hF8, no stall, 3 clks -> PC F8,FC,00,04; misalign_err=0.
REQ-035 EXTRA_FLUSH=1, PC=10, branch_taken=1 with target 8'h40 for one cycle -> unvalid_PC high that cycle and the next; PC=40 then 44; FSM back to RUN.
REQ-036 stall=1 for 3 clks at PC=20 -> PC and instruction constant at 20; a simultaneous branch_taken to 8'h60 on the 2nd stall clk -> PC=60 next, unvalid_PC asserted.
REQ-037 branch to target 8'h33 -> PC=8'h30, misalign_err=1; it stays 1 after further branches until rst.
REQ-038 EXTRA_FLUSH=2, branch to 80, second branch to A0 while in FLUSH, rst pulsed one cycle later -> PC=RESET_PC, state RUN, unvalid_PC=0 in the first post-reset cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, PC step,
// fetch FSM state encoding and the NOP word used by downstream flush logic.
package fetch_unit_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   typedef logic [PC_W-1:0]    pc_t;
   typedef logic [INSTR_W-1:0] instr_t;

   localparam instr_t NOP = '0;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   // Byte addresses are forced onto a word boundary before they reach the PC.
   function automatic pc_t align_pc(input pc_t addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Combinational next-PC select: a taken branch beats stall, and stall beats
// the sequential +4 step (which wraps modulo 256).
module pc_next_mux
   import fetch_unit_pkg::*;
(
   input  logic [PC_W-1:0] pc_i,
   input  logic            stall_i,
   input  logic            branch_taken_i,
   input  logic [PC_W-1:0] branch_target_i,
   output logic [PC_W-1:0] pc_next_o
);

   always_comb begin
      // NOTE: the default assignment before any branch keeps always_comb free of inferred latches.
      pc_next_o = pc_i + PC_W'(PC_STEP);
      if (branch_taken_i) begin
         pc_next_o = align_pc(branch_target_i);
      end else if (stall_i) begin
         pc_next_o = pc_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect/flush FSM with a small flush
// counter, and a sticky misaligned-redirect flag.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     EXTRA_FLUSH = 1,
   parameter logic [PC_W-1:0] RESET_PC    = 8'h00
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [PC_W-1:0]    PC,
   output logic [INSTR_W-1:0] instruction,
   output logic               unvalid_PC,
   output logic               misalign_err
);

   localparam logic [1:0] FLUSH_LOAD = 2'(EXTRA_FLUSH);
   localparam bit         HAS_FLUSH  = (EXTRA_FLUSH != 0);

   pc_t          pc_q;
   pc_t          pc_d;
   fetch_state_e state_q;
   logic [1:0]   fcnt_q;
   logic         misalign_q;

   pc_next_mux u_pc_next_mux (
      .pc_i            (pc_q),
      .stall_i         (stall),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .pc_next_o       (pc_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= align_pc(RESET_PC);
         state_q    <= RUN;
         fcnt_q     <= 2'd0;
         misalign_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         pc_q <= pc_d;
         if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
         end
         // Stall deliberately has no effect here: the flush window keeps counting.
         unique case (state_q)
            RUN: begin
               if (branch_taken && HAS_FLUSH) begin
                  state_q <= FLUSH;
                  fcnt_q  <= FLUSH_LOAD;
               end
            end
            FLUSH: begin
               if (branch_taken) begin
                  fcnt_q <= FLUSH_LOAD;
               end else if (fcnt_q == 2'd1) begin
                  state_q <= RUN;
                  fcnt_q  <= 2'd0;
               end else begin
                  fcnt_q <= fcnt_q - 2'd1;
               end
            end
            default: begin
               state_q <= RUN;
               fcnt_q  <= 2'd0;
            end
         endcase
      end
   end

   assign imem_addr    = pc_q;
   assign PC           = pc_q;
   assign instruction  = imem_data;
   assign unvalid_PC   = branch_taken | (state_q == FLUSH);
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (EXTRA_FLUSH=1 and 2) share stimulus;
// a vector table plus a hand-written reset-in-flush sequence feed a scoreboard.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         stall = 1'b0;
   logic         branch_taken = 1'b0;
   logic [7:0]   branch_target = 8'h00;

   logic [7:0]   imem_addr1, imem_addr2, pc1, pc2;
   logic [31:0]  imem_data1, imem_data2, instr1, instr2;
   logic         unv1, unv2, mis1, mis2;

   function automatic logic [31:0] tag(input logic [7:0] a);
      return {16'hC0DE, ~a, a};
   endfunction

   assign imem_data1 = tag(imem_addr1);
   assign imem_data2 = tag(imem_addr2);

   fetch_unit #(.EXTRA_FLUSH(1), .RESET_PC(8'h00)) dut1 (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_addr(imem_addr1), .imem_data(imem_data1),
      .PC(pc1), .instruction(instr1), .unvalid_PC(unv1), .misalign_err(mis1)
   );

   fetch_unit #(.EXTRA_FLUSH(2), .RESET_PC(8'h00)) dut2 (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_addr(imem_addr2), .imem_data(imem_data2),
      .PC(pc2), .instruction(instr2), .unvalid_PC(unv2), .misalign_err(mis2)
   );

   typedef struct {
      logic       rst;
      logic       stall;
      logic       br;
      logic [7:0] tgt;
      bit         chk;
      logic [7:0] pc;
      logic       unv1;
      logic       unv2;
      logic       mis;
   } vec_t;

   typedef struct {
      bit         chk;
      logic [7:0] pc;
      logic       unv1;
      logic       unv2;
      logic       mis;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [7:0] t,
                               input logic [7:0] p, input logic u1, input logic u2, input logic m);
      vec_t v;
      v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.chk = 1'b1;
      v.pc = p; v.unv1 = u1; v.unv2 = u2; v.mis = m;
      return v;
   endfunction

   // Drive one cycle's inputs after negedge, record the expectation, and
   // compare the combinational outputs before the next rising edge.
   task automatic step(input string lbl, input vec_t v);
      exp_t e;
      @(negedge clk);
      rst = v.rst; stall = v.stall; branch_taken = v.br; branch_target = v.tgt;
      e.chk = v.chk; e.pc = v.pc; e.unv1 = v.unv1; e.unv2 = v.unv2; e.mis = v.mis;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      if (e.chk) begin
         check({lbl, " pc1"},    32'(pc1),        32'(e.pc));
         check({lbl, " addr1"},  32'(imem_addr1), 32'(e.pc));
         check({lbl, " instr1"}, instr1,          tag(e.pc));
         check({lbl, " unv1"},   32'(unv1),       32'(e.unv1));
         check({lbl, " mis1"},   32'(mis1),       32'(e.mis));
         check({lbl, " pc2"},    32'(pc2),        32'(e.pc));
         check({lbl, " instr2"}, instr2,          tag(e.pc));
         check({lbl, " unv2"},   32'(unv2),       32'(e.unv2));
         check({lbl, " mis2"},   32'(mis2),       32'(e.mis));
      end
   endtask

   initial begin
      vec_t rv;
      rv = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      rv.chk = 1'b0;

      //               rst  stall br   tgt    pc     u1   u2   mis
      // sequential fetch after reset
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0));
      // branch at PC=10 to 40, flush window for each instance
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h40, 8'h10, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b1, 1'b0));
      // branch to 20, then stall with a branch to 60 on the 2nd stall clk
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h20, 8'h48, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h60, 8'h20, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h60, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h60, 1'b0, 1'b1, 1'b0));
      // branch to F8 and wrap through FC -> 00 -> 04
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hF8, 8'h64, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hF8, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      // misaligned target 33 -> PC 30, sticky error survives later branches
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h33, 8'h04, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h30, 1'b1, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h34, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h40, 8'h38, 1'b1, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h48, 1'b0, 1'b0, 1'b1));

      step("reset", rv);
      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("row%0d", i), tbl[i]);
      end

      // Branch to 80, re-branch to A0 inside the flush window, then reset mid-flush.
      step("seq_br80",  mk(1'b0, 1'b0, 1'b1, 8'h80, 8'h4C, 1'b1, 1'b1, 1'b1));
      step("seq_brA0",  mk(1'b0, 1'b0, 1'b1, 8'hA0, 8'h80, 1'b1, 1'b1, 1'b1));
      step("seq_rst",   mk(1'b1, 1'b0, 1'b0, 8'h00, 8'hA0, 1'b1, 1'b1, 1'b1));
      step("seq_post0", mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      // Reset wins over a simultaneous misaligned branch and stall.
      step("seq_rstbr", mk(1'b1, 1'b1, 1'b1, 8'h33, 8'h04, 1'b1, 1'b1, 1'b0));
      step("seq_post1", mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      step("seq_post2", mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0));

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
